onchip_mem_dp: RTL and testbench

//  Parametrised true-dual-port on-chip RAM for the processor system; two Avalon-MM slaves (s1, s2).

---
 rtl/onchip_mem_dp_pkg.sv | 11 +
 rtl/onchip_mem_dp_if.sv | 24 ++
 rtl/onchip_mem_rd_pipe.sv | 31 +++
 rtl/onchip_mem_dp.sv | 65 ++++++
 tb/tb_onchip_mem_dp.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/onchip_mem_dp_pkg.sv
// onchip_mem_pkg: shared constants and helpers for the dual-port on-chip RAM
package onchip_mem_pkg;
  localparam int BYTE_W = 8;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 2;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/onchip_mem_dp_if.sv
// onchip_mem_dp_if: one Avalon-MM slave port of the dual-port on-chip RAM
interface onchip_mem_dp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 13
) ();
  import onchip_mem_pkg::*;
  logic [ADDR_W-1:0] address;
  logic chipselect;
  logic read;
  logic write;
  logic [DATA_W/BYTE_W-1:0] byteenable;
  logic [DATA_W-1:0] writedata;
  logic waitrequest;
  logic [DATA_W-1:0] readdata;
  logic readdatavalid;
  modport master (
    output address, chipselect, read, write, byteenable, writedata,
    input waitrequest, readdata, readdatavalid
  );
  modport slave (
    input address, chipselect, read, write, byteenable, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/onchip_mem_rd_pipe.sv
// onchip_mem_rd_pipe: read-response shift stage, held while clken is low
module onchip_mem_rd_pipe #(
  parameter int DATA_W = 32,
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clken,
  input  logic in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic out_valid,
  output logic [DATA_W-1:0] out_data
);
  logic [LAT-1:0] v;
  logic [DATA_W-1:0] d [LAT];
  // Advance one stage per enabled cycle; empty slots carry zero data so readdata is 0 off the valid pulse
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      v <= '0;
      for (int k = 0; k < LAT; k++) d[k] <= '0;
    end else if (clken) begin
      v[0] <= in_valid;
      d[0] <= in_valid ? in_data : '0;
      for (int k = 1; k < LAT; k++) begin
        v[k] <= v[k-1];
        d[k] <= d[k-1];
      end
    end
  assign out_valid = v[LAT-1];
  assign out_data = d[LAT-1];
endmodule

// File: rtl/onchip_mem_dp.sv
// onchip_mem_dp: true-dual-port on-chip RAM with two Avalon-MM slaves and byte-lane collision merge
module onchip_mem_dp
  import onchip_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH = 5120,
  parameter int ADDR_W = 13,
  parameter int READ_LATENCY = 1,
  parameter string INIT_FILE = "onchip_mem_dp.hex"
) (
  input logic clk,
  input logic reset_n,
  input logic clken,
  input logic reset_req,
  onchip_mem_dp_if.slave s1,
  onchip_mem_dp_if.slave s2
);
  localparam int BE_W = DATA_W / BYTE_W;
  localparam int LIM_W = ADDR_W + 1;
  localparam logic [ADDR_W:0] LIMIT = LIM_W'(DEPTH);
  if (READ_LATENCY < LAT_MIN || READ_LATENCY > LAT_MAX || DATA_W % BYTE_W != 0 || ADDR_W < clog2(DEPTH)) begin : g_bad_params
    $error("onchip_mem_dp: illegal READ_LATENCY, DATA_W or ADDR_W");
  end
  logic stall;
  logic [1:0] acc, wr, rd, hit, qv;
  logic [ADDR_W-1:0] addr [2];
  logic [BE_W-1:0] be [2];
  logic [DATA_W-1:0] wdata [2], rdata [2], q [2];
  logic [DATA_W-1:0] mem [DEPTH];
  assign stall = reset_req | ~clken;
  assign s1.waitrequest = stall;
  assign s2.waitrequest = stall;
  always_comb begin
    addr[0] = s1.address;
    addr[1] = s2.address;
    be[0] = s1.byteenable;
    be[1] = s2.byteenable;
    wdata[0] = s1.writedata;
    wdata[1] = s2.writedata;
    acc = {s2.chipselect & (s2.read | s2.write), s1.chipselect & (s1.read | s1.write)} & {2{~stall}};
    wr = acc & {s2.write, s1.write};
    rd = acc & ~{s2.write, s1.write};
    for (int p = 0; p < 2; p++) begin
      hit[p] = {1'b0, addr[p]} < LIMIT;
      rdata[p] = (rd[p] & hit[p]) ? mem[addr[p]] : '0;
    end
  end
  always_ff @(posedge clk)
    for (int p = 1; p >= 0; p--)
      if (wr[p] && hit[p])
        for (int i = 0; i < BE_W; i++)
          if (be[p][i]) mem[addr[p]][i*BYTE_W +: BYTE_W] <= wdata[p][i*BYTE_W +: BYTE_W];
  onchip_mem_rd_pipe #(.DATA_W(DATA_W), .LAT(READ_LATENCY)) u_pipe1 (
    .clk(clk), .reset_n(reset_n), .clken(clken),
    .in_valid(rd[0]), .in_data(rdata[0]), .out_valid(qv[0]), .out_data(q[0])
  );
  onchip_mem_rd_pipe #(.DATA_W(DATA_W), .LAT(READ_LATENCY)) u_pipe2 (
    .clk(clk), .reset_n(reset_n), .clken(clken),
    .in_valid(rd[1]), .in_data(rdata[1]), .out_valid(qv[1]), .out_data(q[1])
  );
  assign s1.readdatavalid = qv[0];
  assign s1.readdata = q[0];
  assign s2.readdatavalid = qv[1];
  assign s2.readdata = q[1];
endmodule

// File: tb/tb_onchip_mem_dp.sv
// tb_onchip_mem_dp: scoreboard bench for the dual-port RAM against a word-array reference model
module tb_onchip_mem_dp;
  localparam int DW = 32;
  localparam int DEPTH = 20;
  localparam int AW = 5;
  localparam int LAT = 2;
  typedef struct { bit cs, rd, wr; int addr; logic [3:0] be; logic [31:0] wd; } op_t;
  typedef struct { int port; logic [31:0] data; int due; } exp_t;
  logic clk = 0, reset_n = 0, clken = 1, reset_req = 0;
  logic [31:0] ref_mem [DEPTH];
  exp_t sb[$];
  int en_cnt = 0, n_chk = 0, n_err = 0;
  int last [2] = '{-1, -1};
  logic [31:0] held [2];
  always #5 clk = ~clk;
  onchip_mem_dp_if #(.DATA_W(DW), .ADDR_W(AW)) m1 ();
  onchip_mem_dp_if #(.DATA_W(DW), .ADDR_W(AW)) m2 ();
  onchip_mem_dp #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .READ_LATENCY(LAT), .INIT_FILE("")) dut (
    .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req), .s1(m1), .s2(m2)
  );
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask
  function automatic op_t mk(bit r, bit w, int a, logic [3:0] be = 4'hf, logic [31:0] wd = 32'h0);
    op_t o;
    o.cs = r | w; o.rd = r; o.wr = w; o.addr = a; o.be = be; o.wd = wd;
    return o;
  endfunction
  function automatic op_t rnd();
    op_t o;
    o.cs = $urandom_range(0, 4) != 0;
    o.rd = $urandom_range(0, 1) == 1;
    o.wr = $urandom_range(0, 2) == 0;
    o.addr = $urandom_range(0, DEPTH + 3);
    o.be = 4'($urandom);
    o.wd = $urandom;
    return o;
  endfunction
  task automatic drive(op_t o, int p);
    if (p == 0) begin
      m1.chipselect = o.cs; m1.read = o.rd; m1.write = o.wr;
      m1.address = 5'(o.addr); m1.byteenable = o.be; m1.writedata = o.wd;
    end else begin
      m2.chipselect = o.cs; m2.read = o.rd; m2.write = o.wr;
      m2.address = 5'(o.addr); m2.byteenable = o.be; m2.writedata = o.wd;
    end
  endtask
  // One bus cycle: reads see the word as it was before this cycle's writes; where both ports
  // enable the same byte of the same word, s1's byte is kept
  task automatic step(op_t a, op_t b);
    op_t o [2];
    o[0] = a; o[1] = b;
    drive(a, 0); drive(b, 1);
    if (reset_n && clken && !reset_req) begin
      for (int p = 0; p < 2; p++)
        if (o[p].cs && o[p].rd && !o[p].wr)
          sb.push_back('{port: p, data: (o[p].addr < DEPTH) ? ref_mem[o[p].addr] : 32'h0, due: en_cnt + LAT});
      for (int p = 0; p < 2; p++)
        if (o[p].cs && o[p].wr && o[p].addr < DEPTH)
          for (int i = 0; i < 4; i++)
            if (o[p].be[i] && !(p == 1 && o[0].cs && o[0].wr && o[0].addr == o[1].addr && o[0].be[i]))
              ref_mem[o[p].addr][8*i +: 8] = o[p].wd[8*i +: 8];
    end
    @(posedge clk);
    #1;
    drive(mk(0, 0, 0), 0); drive(mk(0, 0, 0), 1);
  endtask
  always @(posedge clk) if (reset_n && clken) en_cnt++;
  always @(negedge clk) begin
    chk("s1_waitrequest", {31'h0, m1.waitrequest}, {31'h0, reset_req | ~clken});
    chk("s2_waitrequest", {31'h0, m2.waitrequest}, {31'h0, reset_req | ~clken});
    if (!reset_n) begin
      chk("reset_s1_valid", {31'h0, m1.readdatavalid}, 32'h0);
      chk("reset_s2_valid", {31'h0, m2.readdatavalid}, 32'h0);
      chk("reset_s1_readdata", m1.readdata, 32'h0);
      chk("reset_s2_readdata", m2.readdata, 32'h0);
    end else
      for (int p = 0; p < 2; p++) begin
        logic v;
        logic [31:0] d;
        int idx;
        v = (p == 1) ? m2.readdatavalid : m1.readdatavalid;
        d = (p == 1) ? m2.readdata : m1.readdata;
        idx = -1;
        if (!v) chk($sformatf("s%0d_idle_readdata", p + 1), d, 32'h0);
        else if (en_cnt == last[p]) chk($sformatf("s%0d_held_readdata", p + 1), d, held[p]);
        else begin
          foreach (sb[k]) if (idx < 0 && sb[k].port == p) idx = k;
          if (idx < 0) begin
            n_chk++;
            n_err++;
            $display("FAIL s%0d_unexpected_valid: got readdatavalid with %h, required no response", p + 1, d);
          end else begin
            chk($sformatf("s%0d_readdata", p + 1), d, sb[idx].data);
            chk($sformatf("s%0d_latency", p + 1), en_cnt, sb[idx].due);
            sb.delete(idx);
          end
          last[p] = en_cnt;
          held[p] = d;
        end
      end
  end
  initial begin
    drive(mk(1, 0, 0), 0);
    drive(mk(0, 0, 0), 1);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1;
    drive(mk(0, 0, 0), 0);
    for (int a = 0; a < DEPTH; a += 2)
      step(mk(0, 1, a, 4'hf, a == 0 ? 32'hDEADBEEF : $urandom), mk(0, 1, a + 1, 4'hf, $urandom));
    step(mk(1, 0, 0), mk(0, 0, 0));
    step(mk(0, 1, 5, 4'hf, 32'h11223344), mk(0, 0, 0));
    step(mk(0, 1, 5, 4'h5, 32'hAABBCCDD), mk(0, 0, 0));
    step(mk(1, 0, 5), mk(0, 0, 0));
    step(mk(0, 1, 7, 4'hf, 32'h01020304), mk(1, 0, 7));
    step(mk(0, 1, 7, 4'hc, 32'hFFFF0000), mk(0, 1, 7, 4'h6, 32'h12345678));
    step(mk(1, 0, 7), mk(1, 0, 7));
    for (int a = 0; a < 16; a++) step(mk(1, 0, a), mk(0, 0, 0));
    repeat (3) step(mk(0, 0, 0), mk(0, 0, 0));
    step(mk(1, 0, 3), mk(0, 0, 0));
    step(mk(0, 0, 0), mk(0, 0, 0));
    clken = 0;
    repeat (3) step(mk(0, 1, 3, 4'hf, 32'h55555555), mk(1, 0, 4));
    clken = 1;
    step(mk(1, 0, 4), mk(0, 0, 0));
    clken = 0;
    repeat (3) step(mk(0, 0, 0), mk(0, 1, 4, 4'hf, 32'h66666666));
    clken = 1;
    step(mk(1, 0, 3), mk(1, 0, 4));
    step(mk(1, 0, 6), mk(1, 0, 8));
    reset_req = 1;
    repeat (3) step(mk(1, 0, 9), mk(0, 1, 8, 4'hf, 32'h77777777));
    reset_req = 0;
    step(mk(1, 0, DEPTH), mk(0, 1, DEPTH, 4'hf, 32'hCAFEF00D));
    step(mk(1, 0, DEPTH - 16), mk(1, 0, 8));
    repeat (3) step(mk(0, 0, 0), mk(0, 0, 0));
    step(mk(1, 0, 2), mk(1, 0, 9));
    #2;
    reset_n = 0;
    sb.delete();
    last = '{-1, -1};
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
    repeat (4) step(mk(0, 0, 0), mk(0, 0, 0));
    repeat (400) begin
      clken = $urandom_range(0, 9) != 0;
      reset_req = $urandom_range(0, 19) == 0;
      step(rnd(), rnd());
    end
    clken = 1;
    reset_req = 0;
    for (int a = 0; a < DEPTH; a++) step(mk(1, 0, a), mk(1, 0, DEPTH - 1 - a));
    for (int i = 0; i < 20 && sb.size() > 0; i++) step(mk(0, 0, 0), mk(0, 0, 0));
    if (sb.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL drain_timeout: got %0d outstanding reads, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
